lr_d_h_buffer: RTL
==================

# lr_d_h_buffer

Per-column H replay buffer that sits directly upstream of the 2-column leaky-ReLU derivative stage. During the forward pass it captures the pre-activation H values per column. During the backward pass it replays them in FIFO order, registered together with the incoming gradient stream. Each output column therefore presents a matched {valid, gradient, H} triple in the same cycle, ready for the derivative stage's `lr_d_valid_N_in`, `lr_d_data_N_in` and `lr_d_H_N_in` inputs.

## Interface
Parameters:
- `DEPTH`, 8: entries per column; a power of two, at least 2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `clear_in`  in  1  synchronous flush of both columns.
- `h_valid_1_in`, `h_valid_2_in`  in  1  forward-pass H write strobe, per column.
- `h_data_1_in`, `h_data_2_in`  in  16 signed  H value to store (Q8.8).
- `grad_valid_1_in`, `grad_valid_2_in`  in  1  backward-pass gradient strobe; each strobe is also the H read request.
- `grad_data_1_in`, `grad_data_2_in`  in  16 signed  gradient value.
- `grad_valid_1_out`, `grad_valid_2_out`  out  1  matched-pair valid; feeds `lr_d_valid_N_in`.
- `grad_data_1_out`, `grad_data_2_out`  out  16 signed  registered gradient; feeds `lr_d_data_N_in`.
- `h_data_1_out`, `h_data_2_out`  out  16 signed  replayed H; feeds `lr_d_H_N_in`.
- `count_1_out`, `count_2_out`  out  $clog2(DEPTH)+1  occupancy of each column.
- `full_1_out`, `full_2_out`  out  1  asserted when count == DEPTH.
- `overflow_err_out`  out  1  sticky flag: an H write was dropped.
- `underflow_err_out`  out  1  sticky flag: a gradient arrived with no H stored.

## Operation
- Columns are fully independent: separate memory, `wr_ptr`, `rd_ptr` and count each.
  - Pointers are `$clog2(DEPTH)` bits wide and wrap modulo DEPTH.
- All full/empty decisions in a cycle use the count registered at the start of that cycle. There is no write-to-read bypass.
- Read, per column: when `grad_valid_N_in` = 1 and count > 0:
  - next cycle, `grad_valid_N_out` = 1, `grad_data_N_out` = `grad_data_N_in`, `h_data_N_out` = mem[`rd_ptr`];
  - `rd_ptr` increments.
- Underflow: when `grad_valid_N_in` = 1 and count == 0:
  - the gradient is dropped;
  - next cycle `grad_valid_N_out` = 0;
  - `underflow_err_out` is set.
- Write, per column: when `h_valid_N_in` = 1, the value is stored at `wr_ptr` and `wr_ptr` increments, provided either:
  - count < DEPTH, or
  - a read is accepted in the same cycle.
- Overflow: when `h_valid_N_in` = 1, count == DEPTH and no read is accepted:
  - the value is dropped;
  - memory and pointers are unchanged;
  - `overflow_err_out` is set.
- Count update: +1 on write only, −1 on read only, unchanged on simultaneous write and read.
- Whenever `grad_valid_N_out` = 0, `grad_data_N_out` and `h_data_N_out` are driven to 0. Outputs never hold stale data.
- `clear_in` = 1:
  - next cycle, all pointers, counts, valids, data outputs and both sticky errors are 0;
  - writes and reads in the same cycle are ignored and raise no error flags;
  - memory contents are don't-care.
- Sticky errors clear only on `rst` or `clear_in`.
- No arithmetic is performed. Values pass through bit-exact.

## Timing
- Reset: every output is 0 (valids, data, counts, fulls, errors), and all pointers are 0.
  - Reset mid-stream discards all stored H and any in-flight output pair immediately (asynchronous).
- Latency from `grad_valid_N_in` to `grad_valid_N_out` is exactly 1 cycle. Throughput is one pair per column per cycle.
- Write-to-readable latency is 1 cycle: H written in cycle t is readable by a gradient arriving in cycle t+1, not in cycle t.
- `count_N_out` and `full_N_out` are registered. Each reflects the state after the previous edge.
- Error flags assert on the edge following the offending cycle.
- Columns may be skewed arbitrarily, including the one-cycle systolic skew between column 1 and column 2. No cross-column coupling exists.

## Test plan
- Ordered replay:
  - Stimulus: write `h_data_1_in` = 0x0100, 0xFF00, 0x0080 on consecutive cycles, then assert `grad_valid_1_in` for 3 cycles with `grad_data_1_in` = 0x0200, 0x0300, 0x0400.
  - Response: one cycle later, outputs (0x0200, 0x0100), (0x0300, 0xFF00), (0x0400, 0x0080) with valid = 1; `count_1_out` steps 3 → 0.
- Overflow:
  - Stimulus: 9 consecutive writes to column 2 with DEPTH = 8 and no reads.
  - Response: `count_2_out` = 8, `full_2_out` = 1, `overflow_err_out` = 1. Subsequent reads return the first 8 values; the 9th is absent.
- Underflow:
  - Stimulus: `grad_valid_1_in` = 1 with column 1 empty, plus a write to column 1 in the same cycle.
  - Response: next cycle `grad_valid_1_out` = 0, data outputs = 0, `underflow_err_out` = 1, `count_1_out` = 1.
- Full with simultaneous read and write, plus wrap:
  - Stimulus: fill column 1 with 0..7, then issue 8 cycles of simultaneous write (values 8..15) and read.
  - Response: H replay is 0..7; count stays 8; no overflow. A further 8 reads return 8..15, confirming correct pointer wrap.
- Skewed columns:
  - Stimulus: column 2 stimulus delayed one cycle relative to column 1 (H values 0x0010..0x0013 and 0x0020..0x0023).
  - Response: each column replays its own values in order, with output valids skewed by one cycle.
- Clear and reset mid-stream:
  - Stimulus (clear): `clear_in` pulsed while reads are active and error flags are set.
  - Response (clear): next cycle all outputs, counts and errors = 0.
  - Stimulus (reset): `rst` asserted asynchronously mid-cycle.
  - Response (reset): outputs go to 0 immediately; after release, the first gradient with no new write flags underflow.

Source files
------------

// File: rtl/lr_d_h_buffer_if.sv
// Two-column bundle between the H/gradient producers and the replay buffer.
// master drives forward-pass H and backward-pass gradients; slave is the buffer.
interface lr_d_h_buffer_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                 clear_in;
    logic                 h_valid_1_in;
    logic                 h_valid_2_in;
    logic signed [15:0]   h_data_1_in;
    logic signed [15:0]   h_data_2_in;
    logic                 grad_valid_1_in;
    logic                 grad_valid_2_in;
    logic signed [15:0]   grad_data_1_in;
    logic signed [15:0]   grad_data_2_in;
    logic                 grad_valid_1_out;
    logic                 grad_valid_2_out;
    logic signed [15:0]   grad_data_1_out;
    logic signed [15:0]   grad_data_2_out;
    logic signed [15:0]   h_data_1_out;
    logic signed [15:0]   h_data_2_out;
    logic [CW-1:0]        count_1_out;
    logic [CW-1:0]        count_2_out;
    logic                 full_1_out;
    logic                 full_2_out;
    logic                 overflow_err_out;
    logic                 underflow_err_out;

    modport master (
        output clear_in,
        output h_valid_1_in, h_valid_2_in, h_data_1_in, h_data_2_in,
        output grad_valid_1_in, grad_valid_2_in, grad_data_1_in, grad_data_2_in,
        input  grad_valid_1_out, grad_valid_2_out, grad_data_1_out, grad_data_2_out,
        input  h_data_1_out, h_data_2_out, count_1_out, count_2_out,
        input  full_1_out, full_2_out, overflow_err_out, underflow_err_out
    );

    modport slave (
        input  clear_in,
        input  h_valid_1_in, h_valid_2_in, h_data_1_in, h_data_2_in,
        input  grad_valid_1_in, grad_valid_2_in, grad_data_1_in, grad_data_2_in,
        output grad_valid_1_out, grad_valid_2_out, grad_data_1_out, grad_data_2_out,
        output h_data_1_out, h_data_2_out, count_1_out, count_2_out,
        output full_1_out, full_2_out, overflow_err_out, underflow_err_out
    );
endinterface

// File: rtl/lr_d_h_buffer.sv
// Per-column H replay FIFO pairing stored H with incoming gradients; 1-cycle grad->pair latency.
// No backpressure: writes to a full column and gradients on an empty column are dropped and flagged.
module lr_d_h_buffer #(
    parameter int DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    lr_d_h_buffer_if.slave      bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [1:0]        h_vld;
    logic [1:0][15:0]  h_dat;
    logic [1:0]        g_vld;
    logic [1:0][15:0]  g_dat;
    logic [1:0]        o_vld;
    logic [1:0][15:0]  o_grad;
    logic [1:0][15:0]  o_h;
    logic [1:0][CW-1:0] o_cnt;
    logic [1:0]        o_full;
    logic [1:0]        ovf_set;
    logic [1:0]        unf_set;
    logic              ovf_err;
    logic              unf_err;

    assign h_vld = {bus.h_valid_2_in, bus.h_valid_1_in};
    assign h_dat = {bus.h_data_2_in, bus.h_data_1_in};
    assign g_vld = {bus.grad_valid_2_in, bus.grad_valid_1_in};
    assign g_dat = {bus.grad_data_2_in, bus.grad_data_1_in};

    for (genvar c = 0; c < 2; c++) begin : g_col
        logic [15:0]   mem [DEPTH];
        logic [PW-1:0] wr_ptr;
        logic [PW-1:0] rd_ptr;
        logic [CW-1:0] cnt;
        logic          vld_q;
        logic [15:0]   grad_q;
        logic [15:0]   h_q;
        logic          empty;
        logic          full;
        logic          rd_acc;
        logic          wr_acc;

        // Decisions use the count at the start of the cycle: a read frees the
        // slot a same-cycle write needs, but a same-cycle write never feeds a read.
        assign empty  = (cnt == '0);
        assign full   = (cnt == CW'(DEPTH));
        assign rd_acc = g_vld[c] && !empty;
        assign wr_acc = h_vld[c] && (!full || rd_acc);

        assign ovf_set[c] = h_vld[c] && full && !rd_acc;
        assign unf_set[c] = g_vld[c] && empty;

        always_ff @(posedge clk) begin
            if (wr_acc && !bus.clear_in)
                mem[wr_ptr] <= h_dat[c];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                vld_q  <= 1'b0;
                grad_q <= '0;
                h_q    <= '0;
            end else if (bus.clear_in) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                vld_q  <= 1'b0;
                grad_q <= '0;
                h_q    <= '0;
            end else begin
                if (wr_acc)
                    wr_ptr <= wr_ptr + PW'(1);
                if (rd_acc)
                    rd_ptr <= rd_ptr + PW'(1);
                if (wr_acc && !rd_acc)
                    cnt <= cnt + CW'(1);
                else if (rd_acc && !wr_acc)
                    cnt <= cnt - CW'(1);
                vld_q  <= rd_acc;
                grad_q <= rd_acc ? g_dat[c] : 16'h0;
                h_q    <= rd_acc ? mem[rd_ptr] : 16'h0;
            end
        end

        assign o_vld[c]  = vld_q;
        assign o_grad[c] = grad_q;
        assign o_h[c]    = h_q;
        assign o_cnt[c]  = cnt;
        assign o_full[c] = full;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else if (bus.clear_in) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            ovf_err <= ovf_err || (|ovf_set);
            unf_err <= unf_err || (|unf_set);
        end
    end

    assign bus.grad_valid_1_out  = o_vld[0];
    assign bus.grad_valid_2_out  = o_vld[1];
    assign bus.grad_data_1_out   = o_grad[0];
    assign bus.grad_data_2_out   = o_grad[1];
    assign bus.h_data_1_out      = o_h[0];
    assign bus.h_data_2_out      = o_h[1];
    assign bus.count_1_out       = o_cnt[0];
    assign bus.count_2_out       = o_cnt[1];
    assign bus.full_1_out        = o_full[0];
    assign bus.full_2_out        = o_full[1];
    assign bus.overflow_err_out  = ovf_err;
    assign bus.underflow_err_out = unf_err;
endmodule
